// File: rtl/fstage_bus_pkg.sv
// Shared definitions for the fetch stage: state encodings, AXI response codes,
// reset PC default and the core-variant switch.
package fstage_bus_pkg;

  typedef enum logic [1:0] {
    FS_AR      = 2'd0,
    FS_R       = 2'd1,
    FS_HOLD    = 2'd2,
    FS_WAIT_PC = 2'd3
  } fstate_e;

  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  // The multi-cycle fetch stage has no meaning in the single-cycle core.
  localparam bit          SINGLE_CYCLE     = 1'b0;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fstage_bus.sv
// Instruction fetch stage: one AXI4-Lite read per instruction, result held for decode.
// Latency AR entry -> m_valid is 2 cycles minimum; each handshake stalls its own state.
module fstage_bus
  import fstage_bus_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter logic [31:0] ILLEGAL_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] dnpc,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] instF,
  output logic [31:0] pcF,
  output logic [31:0] snpcF,
  output logic        fetch_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  if (SINGLE_CYCLE) begin : g_unsupported
    $error("fstage_bus cannot be built for the single-cycle core");
  end

  fstate_e     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] snpc_q, snpc_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FS_AR;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pcf_q   <= RESET_PC;
      snpc_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcf_q   <= pcf_d;
      snpc_q  <= snpc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcf_d   = pcf_q;
    snpc_d  = snpc_q;
    err_d   = err_q;
    unique case (state_q)
      FS_AR: if (arready) state_d = FS_R;
      FS_R: begin
        if (rvalid) begin
          inst_d  = (rresp == AXI_RESP_OKAY) ? rdata : ILLEGAL_INST;
          pcf_d   = pc_q;
          snpc_d  = pc_q + 32'd4;
          // A misaligned PC is still fetched; the fault travels with the instruction.
          err_d   = (rresp != AXI_RESP_OKAY) | pc_misaligned(pc_q);
          state_d = FS_HOLD;
        end
      end
      FS_HOLD: if (m_ready) state_d = FS_WAIT_PC;
      FS_WAIT_PC: begin
        if (s_valid) begin
          pc_d    = dnpc;
          state_d = FS_AR;
        end
      end
      default: state_d = FS_AR;
    endcase
  end

  // Handshake outputs depend on state only, so no input reaches an output combinationally.
  assign arvalid   = (state_q == FS_AR);
  assign rready    = (state_q == FS_R);
  assign m_valid   = (state_q == FS_HOLD);
  assign s_ready   = (state_q == FS_WAIT_PC);
  assign araddr    = pc_q;
  assign instF     = inst_q;
  assign pcF       = pcf_q;
  assign snpcF     = snpc_q;
  assign fetch_err = err_q;

  a_rvalid_only_in_r : assert property (@(posedge clk) disable iff (!rst)
    rvalid |-> (state_q == FS_R))
    else $error("rvalid asserted outside the R state");

endmodule

// File: tb/tb_fstage_bus.sv
// Directed bench for fstage_bus: walks the fetch FSM cycle by cycle and checks
// each output against hand-computed values.
module tb_fstage_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] dnpc, instF, pcF, snpcF, araddr, rdata;
  logic        fetch_err, arvalid, arready, rvalid, rready;
  logic [1:0]  rresp;

  int n_checks = 0;
  int n_errors = 0;

  fstage_bus dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .dnpc(dnpc),
    .m_valid(m_valid), .m_ready(m_ready),
    .instF(instF), .pcF(pcF), .snpcF(snpcF), .fetch_err(fetch_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hs(input string tag, input logic av, input logic rr,
                        input logic mv, input logic sr);
    chk({tag, ".arvalid"}, {31'b0, arvalid}, {31'b0, av});
    chk({tag, ".rready"},  {31'b0, rready},  {31'b0, rr});
    chk({tag, ".m_valid"}, {31'b0, m_valid}, {31'b0, mv});
    chk({tag, ".s_ready"}, {31'b0, s_ready}, {31'b0, sr});
  endtask

  task automatic chk_out(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] snpc, input logic err);
    chk({tag, ".instF"},     instF, inst);
    chk({tag, ".pcF"},       pcF, pc);
    chk({tag, ".snpcF"},     snpcF, snpc);
    chk({tag, ".fetch_err"}, {31'b0, fetch_err}, {31'b0, err});
  endtask

  // From AR with zero-wait handshakes: check address, return one beat, land in HOLD.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] resp);
    chk({tag, ".araddr"}, araddr, addr);
    chk_hs({tag, ".ar"}, 1'b1, 1'b0, 1'b0, 1'b0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk_hs({tag, ".r"}, 1'b0, 1'b1, 1'b0, 1'b0);
    rvalid = 1'b1; rdata = data; rresp = resp;
    step();
    rvalid = 1'b0;
    chk_hs({tag, ".hold"}, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // From HOLD: decode accepts, writeback returns next PC, back in AR.
  task automatic next_pc(input string tag, input logic [31:0] npc);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk_hs({tag, ".wait"}, 1'b0, 1'b0, 1'b0, 1'b1);
    s_valid = 1'b1; dnpc = npc;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0; dnpc = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_hs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("reset", 32'h0, 32'h8000_0000, 32'h0, 1'b0);
    chk("reset.araddr", araddr, 32'h8000_0000);
    rst = 1'b1;

    // First fetch, zero wait states: m_valid on the third cycle.
    fetch("t1", 32'h8000_0000, 32'h0000_0413, 2'b00);
    chk_out("t1", 32'h0000_0413, 32'h8000_0000, 32'h8000_0004, 1'b0);

    // Decode stalls four cycles; outputs must hold.
    for (int i = 0; i < 4; i++) begin
      step();
      chk_hs("t3.stall", 1'b0, 1'b0, 1'b1, 1'b0);
      chk_out("t3.stall", 32'h0000_0413, 32'h8000_0000, 32'h8000_0004, 1'b0);
    end
    next_pc("t4", 32'h8000_0100);

    // AR stalls five cycles before arready; address must hold, no rready yet.
    for (int i = 0; i < 5; i++) begin
      chk("t2.araddr", araddr, 32'h8000_0100);
      chk_hs("t2.arstall", 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    // R stalls two cycles before the error beat arrives.
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_hs("t5.rstall", 1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    step();
    rvalid = 1'b0;
    chk_hs("t5.hold", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("t5.slverr", 32'h0, 32'h8000_0100, 32'h8000_0104, 1'b1);

    // Misaligned PC: data passes through but fetch_err flags it.
    next_pc("t7", 32'h8000_0202);
    fetch("t7", 32'h8000_0202, 32'h1234_5678, 2'b00);
    chk_out("t7.misalign", 32'h1234_5678, 32'h8000_0202, 32'h8000_0206, 1'b1);

    // Aligned OKAY fetch clears the error; snpc wraps at 2^32.
    next_pc("t8", 32'hFFFF_FFFC);
    fetch("t8", 32'hFFFF_FFFC, 32'h0010_0073, 2'b00);
    chk_out("t8.wrap", 32'h0010_0073, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

    // Reset asserted while in R: outputs return to reset values without a clock.
    next_pc("t6", 32'h8000_0400);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk_hs("t6.inr", 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_hs("t6.async", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("t6.async", 32'h0, 32'h8000_0000, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    fetch("t6.restart", 32'h8000_0000, 32'h0000_0013, 2'b00);
    chk_out("t6.restart", 32'h0000_0013, 32'h8000_0000, 32'h8000_0004, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
